ctrl_pipe_hzd: RTL and testbench
================================

// Module: ctrl_pipe_hzd
// PURPOSE
//  Parametrised control-word pipeline for the 5-stage core: carries decoded control from D through E, M, W.
//  Adds per-stage valid bits, per-stage stall (hold) and flush (bubble), and built-in load-use hazard detection.
//  Adds a retired-instruction counter. Sits between maindec (D) and the datapath stage muxes.
// PARAMETERS
//  EW        8   width of control field consumed in E only (aluop, alusrc, regdst, sign_ext ...)
//  MW        2   width of control field consumed in M (memwrite, memread ...)
//  WW        2   width of control field consumed in W (memtoreg, regwrite ...)
//  MEMRD_BIT 0   bit index inside M field that marks a load
//  RW        5   register-index width
//  CNT_W     32  retired-instruction counter width
// PORTS
//  clk       in   1            rising-edge clock
//  rst       in   1            synchronous reset, active-high
//  ctrlD     in   EW+MW+WW     decoded control, packed {E,M,W} (W in LSBs)
//  validD    in   1            D holds a real instruction
//  rsD,rtD   in   RW each      source registers in D
//  use_rtD   in   1            instruction in D reads rt
//  writeregE in   RW           destination register resolved in E
//  stallE    in   1            external hold request for E (e.g. multicycle ALU)
//  stallM    in   1            external hold request for M (memory wait)
//  flushE    in   1            bubble into E next cycle (branch/jump redirect)
//  flushM    in   1            bubble into M next cycle (exception)
//  stallD_o  out  1            D/F must hold this cycle
//  ctrlE_o   out  EW+MW+WW     E-stage control; validE_o out 1
//  ctrlM_o   out  MW+WW        M-stage control; validM_o out 1
//  ctrlW_o   out  WW           W-stage control; validW_o out 1
//  instret_o out  CNT_W        count of instructions retired in W
// BEHAVIOUR
//  - Reset: all ctrl*_o, valid*_o, instret_o = 0; stallD_o combinational (0 while stages empty).
//  - Bubble = stage register loaded with all-zero control and valid 0; control is never non-zero while valid=0.
//  - lu = validD & validE & ctrlE_o[WW+MEMRD_BIT] & (writeregE!=0) & ((writeregE==rsD) | (use_rtD & writeregE==rtD)).
//  - holdM = stallM; holdE = stallE | stallM; stallD_o = lu | holdE (combinational, same cycle).
//  - Per-stage update priority at posedge: rst > flush > hold > advance.
//    E: flushE -> bubble; else holdE -> keep; else lu -> bubble; else load {ctrlD, validD}.
//    M: flushM -> bubble; else holdM -> keep; else holdE -> bubble; else load E (drop E field).
//    W: holdM -> bubble; else load M (drop M field). W never holds.
//  - Latency D->W = 3 cycles with no stalls; each hold cycle adds one.
//  - flushE with stallE simultaneous: flush wins, E becomes bubble; D still held (stallD_o=1).
//  - lu with flushE: bubble (same result); lu with holdE: E keeps current contents.
//  - instret_o += 1 each cycle validW_o=1; wraps modulo 2^CNT_W, no saturation.
//  - rst mid-stream: all stages empty next cycle, counter cleared; in-flight instructions discarded.
//  - writeregE==0 never triggers lu (r0 not a real dependency).
// TESTING
//  1 Reset then ctrlD=0x0F5A,validD=1 for 1 cycle -> ctrlE_o=0x0F5A @+1, ctrlM_o=0x05A-field @+2, ctrlW_o @+3, instret_o=1 @+4.
//  2 lw $8 in E (memread=1, writeregE=8), D reads rsD=8 -> stallD_o=1 same cycle, E bubble next cycle, D reissued, no double count.
//  3 Same as 2 but writeregE=0 or use_rtD=0 with rtD=8 only -> stallD_o=0, no bubble.
//  4 stallM=1 for 3 cycles with full pipe -> M,E hold values, W gets 3 bubbles (validW_o=0), stallD_o=1, instret frozen.
//  5 flushE and stallE together, then flushM alone -> E bubble despite stall; next M bubble; valids and ctrl fields all 0.
//  6 CNT_W=4, 17 back-to-back valid instructions -> instret_o wraps 15->0->1; rst mid-stream clears all outputs next edge.

Source files
------------

// File: rtl/ctrl_pipe_hzd.sv
// ctrl_pipe_hzd
// Carries decoded control from D through the E, M and W stage registers of the
// 5-stage core. Each stage has a valid bit, can hold (stall) or take a bubble
// (flush). Load-use hazards against the instruction in E are detected here.
// A counter tracks the number of instructions retired in W.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   ctrlD, validD   decoded control {E,M,W} (W in LSBs) and valid from D
//   rsD, rtD        source registers in D; use_rtD = D reads rt
//   writeregE       destination register resolved in E
//   stallE, stallM  external hold requests for E and M
//   flushE, flushM  bubble requests for E and M
//   stallD_o        D/F must hold this cycle (combinational)
//   ctrlE_o/validE_o, ctrlM_o/validM_o, ctrlW_o/validW_o  stage contents
//   instret_o       retired-instruction count, wraps modulo 2^CNT_W
module ctrl_pipe_hzd #(
    parameter int EW        = 8,
    parameter int MW        = 2,
    parameter int WW        = 2,
    parameter int MEMRD_BIT = 0,
    parameter int RW        = 5,
    parameter int CNT_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [EW+MW+WW-1:0]   ctrlD,
    input  logic                  validD,
    input  logic [RW-1:0]         rsD,
    input  logic [RW-1:0]         rtD,
    input  logic                  use_rtD,
    input  logic [RW-1:0]         writeregE,
    input  logic                  stallE,
    input  logic                  stallM,
    input  logic                  flushE,
    input  logic                  flushM,
    output logic                  stallD_o,
    output logic [EW+MW+WW-1:0]   ctrlE_o,
    output logic                  validE_o,
    output logic [MW+WW-1:0]      ctrlM_o,
    output logic                  validM_o,
    output logic [WW-1:0]         ctrlW_o,
    output logic                  validW_o,
    output logic [CNT_W-1:0]      instret_o
);

    localparam int CW  = EW + MW + WW;
    localparam int MWW = MW + WW;

    logic [CW-1:0]    ctrlE_q, ctrlE_d;
    logic             validE_q, validE_d;
    logic [MWW-1:0]   ctrlM_q, ctrlM_d;
    logic             validM_q, validM_d;
    logic [WW-1:0]    ctrlW_q, ctrlW_d;
    logic             validW_q, validW_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic lu;
    logic hold_e;
    logic hold_m;

    // r0 is never a real dependency, so writeregE == 0 cannot raise a hazard.
    assign lu = validD & validE_q & ctrlE_q[WW+MEMRD_BIT] & (writeregE != '0)
              & ((writeregE == rsD) | (use_rtD & (writeregE == rtD)));

    // A memory wait backs up through E as well.
    assign hold_m   = stallM;
    assign hold_e   = stallE | stallM;
    assign stallD_o = lu | hold_e;

    always_comb begin
        ctrlE_d   = ctrlE_q;
        validE_d  = validE_q;
        ctrlM_d   = ctrlM_q;
        validM_d  = validM_q;
        ctrlW_d   = '0;
        validW_d  = 1'b0;
        instret_d = instret_q;

        if (flushE) begin
            ctrlE_d  = '0;
            validE_d = 1'b0;
        end else if (hold_e) begin
            ctrlE_d  = ctrlE_q;
            validE_d = validE_q;
        end else if (lu) begin
            ctrlE_d  = '0;
            validE_d = 1'b0;
        end else begin
            // Gate with valid so a bubble never carries stray control bits.
            ctrlE_d  = validD ? ctrlD : '0;
            validE_d = validD;
        end

        if (flushM) begin
            ctrlM_d  = '0;
            validM_d = 1'b0;
        end else if (hold_m) begin
            ctrlM_d  = ctrlM_q;
            validM_d = validM_q;
        end else if (hold_e) begin
            // E is held but M is free: M drains and takes a bubble.
            ctrlM_d  = '0;
            validM_d = 1'b0;
        end else begin
            ctrlM_d  = ctrlE_q[MWW-1:0];
            validM_d = validE_q;
        end

        // W never holds; while M is held, W is fed bubbles.
        if (!hold_m) begin
            ctrlW_d  = ctrlM_q[WW-1:0];
            validW_d = validM_q;
        end

        if (validW_q) begin
            instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrlE_q   <= '0;
            validE_q  <= 1'b0;
            ctrlM_q   <= '0;
            validM_q  <= 1'b0;
            ctrlW_q   <= '0;
            validW_q  <= 1'b0;
            instret_q <= '0;
        end else begin
            ctrlE_q   <= ctrlE_d;
            validE_q  <= validE_d;
            ctrlM_q   <= ctrlM_d;
            validM_q  <= validM_d;
            ctrlW_q   <= ctrlW_d;
            validW_q  <= validW_d;
            instret_q <= instret_d;
        end
    end

    assign ctrlE_o   = ctrlE_q;
    assign validE_o  = validE_q;
    assign ctrlM_o   = ctrlM_q;
    assign validM_o  = validM_q;
    assign ctrlW_o   = ctrlW_q;
    assign validW_o  = validW_q;
    assign instret_o = instret_q;

endmodule

// File: tb/tb_ctrl_pipe_hzd.sv
// Directed bench for ctrl_pipe_hzd (CNT_W = 4 so the counter wrap is reachable).
module tb_ctrl_pipe_hzd;

    localparam int EW = 8, MW = 2, WW = 2, RW = 5, CNT_W = 4;
    localparam int CW = EW + MW + WW;

    logic            clk = 1'b0;
    logic            rst;
    logic [CW-1:0]   ctrlD;
    logic            validD;
    logic [RW-1:0]   rsD, rtD, writeregE;
    logic            use_rtD, stallE, stallM, flushE, flushM;
    logic            stallD_o;
    logic [CW-1:0]   ctrlE_o;
    logic            validE_o;
    logic [MW+WW-1:0] ctrlM_o;
    logic            validM_o;
    logic [WW-1:0]   ctrlW_o;
    logic            validW_o;
    logic [CNT_W-1:0] instret_o;

    int n_chk  = 0;
    int n_pass = 0;

    ctrl_pipe_hzd #(
        .EW(EW), .MW(MW), .WW(WW), .MEMRD_BIT(0), .RW(RW), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .ctrlD(ctrlD), .validD(validD),
        .rsD(rsD), .rtD(rtD), .use_rtD(use_rtD), .writeregE(writeregE),
        .stallE(stallE), .stallM(stallM), .flushE(flushE), .flushM(flushM),
        .stallD_o(stallD_o),
        .ctrlE_o(ctrlE_o), .validE_o(validE_o),
        .ctrlM_o(ctrlM_o), .validM_o(validM_o),
        .ctrlW_o(ctrlW_o), .validW_o(validW_o),
        .instret_o(instret_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, " ctrlE"},   32'(ctrlE_o),   32'h0);
        chk({tag, " validE"},  32'(validE_o),  32'h0);
        chk({tag, " ctrlM"},   32'(ctrlM_o),   32'h0);
        chk({tag, " validM"},  32'(validM_o),  32'h0);
        chk({tag, " ctrlW"},   32'(ctrlW_o),   32'h0);
        chk({tag, " validW"},  32'(validW_o),  32'h0);
        chk({tag, " instret"}, 32'(instret_o), 32'h0);
    endtask

    initial begin
        rst = 1'b1; ctrlD = '0; validD = 1'b0; rsD = '0; rtD = '0; use_rtD = 1'b0;
        writeregE = '0; stallE = 1'b0; stallM = 1'b0; flushE = 1'b0; flushM = 1'b0;
        step(); step();
        rst = 1'b0;
        settle();
        chk_empty("reset");
        chk("reset stallD", 32'(stallD_o), 32'h0);

        // 1: single instruction D->W latency
        ctrlD = 12'hF5A; validD = 1'b1;
        step();
        chk("t1 ctrlE", 32'(ctrlE_o), 32'hF5A);
        chk("t1 validE", 32'(validE_o), 32'h1);
        ctrlD = '0; validD = 1'b0;
        step();
        chk("t1 ctrlM", 32'(ctrlM_o), 32'hA);
        chk("t1 validM", 32'(validM_o), 32'h1);
        chk("t1 E bubble", 32'(ctrlE_o), 32'h0);
        step();
        chk("t1 ctrlW", 32'(ctrlW_o), 32'h2);
        chk("t1 validW", 32'(validW_o), 32'h1);
        chk("t1 instret pre", 32'(instret_o), 32'h0);
        step();
        chk("t1 instret", 32'(instret_o), 32'h1);
        chk("t1 W empty", 32'(validW_o), 32'h0);

        // 2: load-use on rs
        ctrlD = 12'h005; validD = 1'b1;
        step();
        chk("t2 lw in E", 32'(ctrlE_o), 32'h005);
        ctrlD = 12'h301; rsD = 5'd8; writeregE = 5'd8;
        settle();
        chk("t2 stallD", 32'(stallD_o), 32'h1);
        step();
        chk("t2 E bubble valid", 32'(validE_o), 32'h0);
        chk("t2 E bubble ctrl", 32'(ctrlE_o), 32'h0);
        chk("t2 lw in M", 32'(ctrlM_o), 32'h5);
        chk("t2 stallD cleared", 32'(stallD_o), 32'h0);
        step();
        chk("t2 reissue E", 32'(ctrlE_o), 32'h301);
        chk("t2 M bubble", 32'(validM_o), 32'h0);
        chk("t2 lw in W", 32'(ctrlW_o), 32'h1);
        validD = 1'b0; ctrlD = '0; rsD = '0; writeregE = '0;
        step();
        chk("t2 instret lw", 32'(instret_o), 32'h2);
        chk("t2 W bubble", 32'(validW_o), 32'h0);
        step();
        chk("t2 instret hold", 32'(instret_o), 32'h2);
        step();
        chk("t2 instret final", 32'(instret_o), 32'h3);

        // 3: no hazard on r0 or when rt is not read
        ctrlD = 12'h005; validD = 1'b1;
        step();
        ctrlD = 12'h301; rsD = 5'd8; writeregE = 5'd0;
        settle();
        chk("t3 r0 stallD", 32'(stallD_o), 32'h0);
        rsD = 5'd3; rtD = 5'd8; writeregE = 5'd8; use_rtD = 1'b1;
        settle();
        chk("t3 rt used stallD", 32'(stallD_o), 32'h1);
        use_rtD = 1'b0;
        settle();
        chk("t3 rt unused stallD", 32'(stallD_o), 32'h0);
        step();
        chk("t3 no bubble valid", 32'(validE_o), 32'h1);
        chk("t3 no bubble ctrl", 32'(ctrlE_o), 32'h301);
        validD = 1'b0; ctrlD = '0; rsD = '0; rtD = '0; writeregE = '0;
        step(); step(); step();
        chk("t3 instret", 32'(instret_o), 32'h5);

        // 4: stallM for three cycles with full pipe
        validD = 1'b1; ctrlD = 12'h0A3; step();
        ctrlD = 12'h0B2; step();
        ctrlD = 12'h0C1; step();
        chk("t4 W full", 32'(ctrlW_o), 32'h3);
        ctrlD = 12'h0D3; stallM = 1'b1;
        settle();
        chk("t4 stallD", 32'(stallD_o), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4 hold E", 32'(ctrlE_o), 32'h0C1);
            chk("t4 hold M", 32'(ctrlM_o), 32'h2);
            chk("t4 W bubble", 32'(validW_o), 32'h0);
            chk("t4 stallD hold", 32'(stallD_o), 32'h1);
            chk("t4 instret frozen", 32'(instret_o), 32'h6);
        end
        stallM = 1'b0;
        settle();
        chk("t4 stallD release", 32'(stallD_o), 32'h0);
        step();
        chk("t4 E adv", 32'(ctrlE_o), 32'h0D3);
        chk("t4 M adv", 32'(ctrlM_o), 32'h1);
        chk("t4 W adv", 32'(ctrlW_o), 32'h2);
        validD = 1'b0; ctrlD = '0;
        step(); step(); step();
        chk("t4 instret", 32'(instret_o), 32'h9);

        // 5: flushE+stallE, then flushM
        validD = 1'b1; ctrlD = 12'h0A3; step();
        ctrlD = 12'h0B2; step();
        ctrlD = 12'h0C1; flushE = 1'b1; stallE = 1'b1;
        settle();
        chk("t5 stallD", 32'(stallD_o), 32'h1);
        step();
        chk("t5 E flushed valid", 32'(validE_o), 32'h0);
        chk("t5 E flushed ctrl", 32'(ctrlE_o), 32'h0);
        chk("t5 M bubble", 32'(validM_o), 32'h0);
        chk("t5 W got A", 32'(ctrlW_o), 32'h3);
        flushE = 1'b0; stallE = 1'b0;
        step();
        chk("t5 E loads C", 32'(ctrlE_o), 32'h0C1);
        flushM = 1'b1; validD = 1'b0; ctrlD = '0;
        step();
        chk("t5 M flushed valid", 32'(validM_o), 32'h0);
        chk("t5 M flushed ctrl", 32'(ctrlM_o), 32'h0);
        flushM = 1'b0;
        step(); step();
        chk("t5 instret", 32'(instret_o), 32'hA);

        // 6: counter wrap from reset, then reset mid-stream
        rst = 1'b1; step(); rst = 1'b0;
        chk_empty("t6 rst");
        validD = 1'b1; ctrlD = 12'h0A3;
        for (int k = 1; k <= 20; k++) begin
            if (k > 17) validD = 1'b0;
            step();
            chk($sformatf("t6 instret k%0d", k), 32'(instret_o),
                (k >= 4) ? 32'((k - 3) % 16) : 32'h0);
        end
        validD = 1'b1;
        step(); step(); step(); step();
        chk("t6 stream running", 32'(instret_o), 32'h2);
        rst = 1'b1;
        step();
        rst = 1'b0; validD = 1'b0; ctrlD = '0;
        chk_empty("t6 midrst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
